// File: rtl/mpc_mac_pipe_sat_if.sv
// Bundle of the beat input, result output and clock-enable signals of mpc_mac_pipe_sat.
//   master : drives ce, in_valid, first, last, a, b; receives p, out_valid, sat, acc_ovf
//   slave  : the MAC pipeline itself
interface mpc_mac_pipe_sat_if #(
  parameter int unsigned A_W   = 21,
  parameter int unsigned B_W   = 7,
  parameter int unsigned OUT_W = 28
);
  logic                    ce;
  logic                    in_valid;
  logic                    first;
  logic                    last;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic signed [OUT_W-1:0] p;
  logic                    out_valid;
  logic                    sat;
  logic                    acc_ovf;

  modport master (
    output ce, in_valid, first, last, a, b,
    input  p, out_valid, sat, acc_ovf
  );

  modport slave (
    input  ce, in_valid, first, last, a, b,
    output p, out_valid, sat, acc_ovf
  );
endinterface

// File: rtl/mpc_mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with round / shift / saturate output stage.
// A frame of a*b products (first..last) is summed in an ACC_W accumulator; on the last beat the
// sum is rounded half-up, arithmetically shifted right by SHIFT and clipped (SAT=1) or wrapped
// (SAT=0) to OUT_W. Four ce-enabled edges from the last beat to out_valid.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset, clears every pipeline register
//   bus    : slave side of mpc_mac_pipe_sat_if (ce, beat inputs, result outputs)
module mpc_mac_pipe_sat #(
  parameter int unsigned A_W   = 21,
  parameter int unsigned B_W   = 7,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned OUT_W = 28,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned SAT   = 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  mpc_mac_pipe_sat_if.slave bus
);

  localparam int unsigned PW     = A_W + B_W;
  localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RndConst =
      (SHIFT > 0) ? ((ACC_W + 1)'(1) << RndPos) : '0;
  localparam logic [OUT_W-1:0] OutMax = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OutMin = {1'b1, {(OUT_W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // S1: input register
  // ---------------------------------------------------------------------------
  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  logic                  v1_q, f1_q, l1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      l1_q <= 1'b0;
    end else if (bus.ce) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      v1_q <= bus.in_valid;
      f1_q <= bus.first;
      l1_q <= bus.last;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: full-width signed product
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] a_ext, b_ext, prod_d, prod_q;
  logic                 v2_q, f2_q, l2_q;

  // Operands sign-extended to PW so the PW-bit product is exact.
  assign a_ext  = {{B_W{a_q[A_W-1]}}, a_q};
  assign b_ext  = {{A_W{b_q[B_W-1]}}, b_q};
  assign prod_d = a_ext * b_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      v2_q   <= 1'b0;
      f2_q   <= 1'b0;
      l2_q   <= 1'b0;
    end else if (bus.ce) begin
      prod_q <= prod_d;
      v2_q   <= v1_q;
      f2_q   <= f1_q;
      l2_q   <= l1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: accumulator with sticky wrap flag
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] prod_sx, acc_sum, acc_d, acc_q;
  logic                    wrap, ovf_d, ovf_q, end_q;

  assign prod_sx = ACC_W'(prod_q);
  assign acc_sum = acc_q + prod_sx;
  // Two's complement overflow: like-signed operands producing an opposite-signed sum.
  assign wrap    = (acc_q[ACC_W-1] == prod_sx[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (v2_q) begin
      if (f2_q) begin
        acc_d = prod_sx;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum;
        ovf_d = ovf_q | wrap;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      end_q <= 1'b0;
    end else if (bus.ce) begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      end_q <= v2_q & l2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S4: round half-up, shift, saturate / wrap
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0]   acc_x, rnd_sum, r;
  logic [ACC_W-OUT_W+1:0]  hi_bits;
  logic                    fits;
  logic [OUT_W-1:0]        p_res;

  // One guard bit so the rounding add cannot wrap.
  assign acc_x   = {acc_q[ACC_W-1], acc_q};
  assign rnd_sum = acc_x + RndConst;
  assign r       = rnd_sum >>> SHIFT;
  // r fits in OUT_W when all bits from the OUT_W sign bit upward agree.
  assign hi_bits = r[ACC_W:OUT_W-1];
  assign fits    = (&hi_bits) | ~(|hi_bits);

  always_comb begin
    p_res = r[OUT_W-1:0];
    if ((SAT != 0) && !fits) begin
      p_res = r[ACC_W] ? OutMin : OutMax;
    end
  end

  logic [OUT_W-1:0] p_q;
  logic             out_valid_q, sat_q, acc_ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else if (bus.ce) begin
      out_valid_q <= end_q;
      if (end_q) begin
        p_q       <= p_res;
        sat_q     <= ~fits;
        acc_ovf_q <= ovf_q;
      end
    end
  end

  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_mpc_mac_pipe_sat.sv
// Directed bench for mpc_mac_pipe_sat: a default instance (SHIFT=0, OUT_W=28) and a narrow
// rounding instance (SHIFT=4, OUT_W=8). Every negedge is a numbered step; out_valid results are
// logged with their step number so latency and pulse counts can be compared per scenario.
module tb_mpc_mac_pipe_sat;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpc_mac_pipe_sat_if #(.A_W(21), .B_W(7), .OUT_W(28)) bus0 ();
  mpc_mac_pipe_sat_if #(.A_W(21), .B_W(7), .OUT_W(8))  bus8 ();

  mpc_mac_pipe_sat #(
    .A_W(21), .B_W(7), .ACC_W(40), .OUT_W(28), .SHIFT(0), .SAT(1)
  ) u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0)
  );

  mpc_mac_pipe_sat #(
    .A_W(21), .B_W(7), .ACC_W(40), .OUT_W(8), .SHIFT(4), .SAT(1)
  ) u_dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus8)
  );

  int errors = 0;
  int checks = 0;
  int step_n = 0;

  typedef struct { int at; int p; logic sat; logic ovf; } res_t;
  res_t q0[$];
  res_t q8[$];

  typedef struct { logic ce; logic v; logic f; logic l; int a; int b; } beat_t;

  task automatic drive0(input logic ce, input logic v, input logic f, input logic l,
                        input int a, input int b);
    bus0.ce = ce; bus0.in_valid = v; bus0.first = f; bus0.last = l;
    bus0.a = 21'(a); bus0.b = 7'(b);
  endtask

  task automatic drive8(input logic ce, input logic v, input logic f, input logic l,
                        input int a, input int b);
    bus8.ce = ce; bus8.in_valid = v; bus8.first = f; bus8.last = l;
    bus8.a = 21'(a); bus8.b = 7'(b);
  endtask

  task automatic tick();
    @(negedge clk);
    step_n++;
    if (bus0.out_valid) q0.push_back(res_t'{step_n, int'(bus0.p), bus0.sat, bus0.acc_ovf});
    if (bus8.out_valid) q8.push_back(res_t'{step_n, int'(bus8.p), bus8.sat, bus8.acc_ovf});
  endtask

  task automatic clear_log();
    step_n = 0;
    q0.delete();
    q8.delete();
  endtask

  task automatic idle(input int n);
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive8(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    #12;
    checks++;
    if (bus0.p !== 28'sd0 || bus0.out_valid !== 1'b0 || bus0.sat !== 1'b0 ||
        bus0.acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs0: got p=%0d ov=%b sat=%b ovf=%b want 0 0 0 0",
               bus0.p, bus0.out_valid, bus0.sat, bus0.acc_ovf);
    end
    checks++;
    if (bus8.p !== 8'sd0 || bus8.out_valid !== 1'b0 || bus8.sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs8: got p=%0d ov=%b sat=%b want 0 0 0",
               bus8.p, bus8.out_valid, bus8.sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Beat with no preceding first: accumulates onto the cleared accumulator.
    clear_log();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 3, 4);
    tick();
    idle(5);
    checks++;
    if (q0.size() !== 1) begin
      errors++;
      $display("FAIL nofirst_count: got %0d results want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 4 || q0[0].p !== 12) begin
        errors++;
        $display("FAIL nofirst_value: got step=%0d p=%0d want step=4 p=12", q0[0].at, q0[0].p);
      end
    end
  endtask

  task automatic test_single_mult();
    clear_log();
    drive0(1'b1, 1'b1, 1'b1, 1'b1, -1048576, -64);
    tick();
    idle(5);
    checks++;
    if (q0.size() !== 1) begin
      errors++;
      $display("FAIL t1_count: got %0d results want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 4 || q0[0].p !== 67108864 || q0[0].sat !== 1'b0 || q0[0].ovf !== 1'b0)
      begin
        errors++;
        $display("FAIL t1_value: got step=%0d p=%0d sat=%b ovf=%b want 4 67108864 0 0",
                 q0[0].at, q0[0].p, q0[0].sat, q0[0].ovf);
      end
    end
    checks++;
    if (bus0.p !== 28'sd67108864) begin
      errors++;
      $display("FAIL t1_hold: got p=%0d want 67108864", bus0.p);
    end
  endtask

  task automatic test_frame();
    clear_log();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 100, 2);   tick();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, -200, 3);  tick();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 300, -1);  tick();
    idle(5);
    checks++;
    if (q0.size() !== 1) begin
      errors++;
      $display("FAIL t2_count: got %0d results want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 6 || q0[0].p !== -700 || q0[0].sat !== 1'b0) begin
        errors++;
        $display("FAIL t2_value: got step=%0d p=%0d sat=%b want 6 -700 0",
                 q0[0].at, q0[0].p, q0[0].sat);
      end
    end
  endtask

  task automatic test_round_sat();
    clear_log();
    drive8(1'b1, 1'b1, 1'b1, 1'b1, 5000, 3); tick();
    drive8(1'b1, 1'b1, 1'b1, 1'b1, -24, 1);  tick();
    drive8(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(5);
    checks++;
    if (q8.size() !== 2) begin
      errors++;
      $display("FAIL t3_count: got %0d results want 2", q8.size());
    end else begin
      checks++;
      if (q8[0].at !== 4 || q8[0].p !== 127 || q8[0].sat !== 1'b1) begin
        errors++;
        $display("FAIL t3_clip: got step=%0d p=%0d sat=%b want 4 127 1",
                 q8[0].at, q8[0].p, q8[0].sat);
      end
      checks++;
      if (q8[1].at !== 5 || q8[1].p !== -1 || q8[1].sat !== 1'b0) begin
        errors++;
        $display("FAIL t3_round: got step=%0d p=%0d sat=%b want 5 -1 0",
                 q8[1].at, q8[1].p, q8[1].sat);
      end
    end
  endtask

  task automatic test_ce_bubbles();
    beat_t tbl [15];
    tbl = '{
      '{1'b1, 1'b1, 1'b1, 1'b0, 100, 2},  '{1'b0, 1'b1, 1'b0, 1'b0, -200, 3},
      '{1'b1, 1'b1, 1'b0, 1'b0, -200, 3}, '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0},    '{1'b0, 1'b1, 1'b0, 1'b1, 300, -1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 300, -1}, '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0},    '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0},    '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0},    '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0}
    };
    clear_log();
    for (int i = 0; i < 15; i++) begin
      drive0(tbl[i].ce, tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].a, tbl[i].b);
      tick();
    end
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    // Result after the 4th enabled edge (step 13), frozen through the ce=0 step 14.
    checks++;
    if (q0.size() !== 2) begin
      errors++;
      $display("FAIL t4_count: got %0d valid steps want 2", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 13 || q0[0].p !== -700) begin
        errors++;
        $display("FAIL t4_value: got step=%0d p=%0d want 13 -700", q0[0].at, q0[0].p);
      end
      checks++;
      if (q0[1].at !== 14 || q0[1].p !== -700) begin
        errors++;
        $display("FAIL t4_freeze: got step=%0d p=%0d want 14 -700", q0[1].at, q0[1].p);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    drive0(1'b1, 1'b1, 1'b1, 1'b1, 7, 7); tick();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 1, 1); tick();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 2, 2); tick();
    idle(5);
    checks++;
    if (q0.size() !== 2) begin
      errors++;
      $display("FAIL t5_count: got %0d results want 2", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 4 || q0[0].p !== 49) begin
        errors++;
        $display("FAIL t5_first: got step=%0d p=%0d want 4 49", q0[0].at, q0[0].p);
      end
      checks++;
      if (q0[1].at !== 6 || q0[1].p !== 5) begin
        errors++;
        $display("FAIL t5_second: got step=%0d p=%0d want 6 5", q0[1].at, q0[1].p);
      end
    end
  endtask

  task automatic test_restart();
    clear_log();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 10, 10); tick();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 2, 3);   tick();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 1, 1);   tick();
    idle(5);
    checks++;
    if (q0.size() !== 1 || q0[0].p !== 7) begin
      errors++;
      $display("FAIL restart: got n=%0d p=%0d want n=1 p=7", q0.size(),
               (q0.size() > 0) ? q0[0].p : 0);
    end
  endtask

  task automatic test_acc_ovf();
    // 8192 * 2^26 = 2^39 wraps the 40-bit accumulator to -2^39 on the last beat.
    clear_log();
    for (int i = 0; i < 8192; i++) begin
      drive0(1'b1, 1'b1, (i == 0), (i == 8191), -1048576, -64);
      tick();
    end
    idle(6);
    checks++;
    if (q0.size() !== 1) begin
      errors++;
      $display("FAIL ovf_count: got %0d results want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 8195 || q0[0].p !== -134217728 || q0[0].sat !== 1'b1 ||
          q0[0].ovf !== 1'b1) begin
        errors++;
        $display("FAIL ovf_value: got step=%0d p=%0d sat=%b ovf=%b want 8195 -134217728 1 1",
                 q0[0].at, q0[0].p, q0[0].sat, q0[0].ovf);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 100, 2);  tick();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, -200, 3); tick();
    #2;
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    #1;
    checks++;
    if (bus0.p !== 28'sd0 || bus0.out_valid !== 1'b0 || bus0.sat !== 1'b0 ||
        bus0.acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL t6_async_clear: got p=%0d ov=%b sat=%b ovf=%b want 0 0 0 0",
               bus0.p, bus0.out_valid, bus0.sat, bus0.acc_ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 4, 6);  tick();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 5, -7); tick();
    idle(6);
    checks++;
    if (q0.size() !== 1) begin
      errors++;
      $display("FAIL t6_count: got %0d results want 1", q0.size());
    end else begin
      checks++;
      if (q0[0].at !== 5 || q0[0].p !== -11 || q0[0].sat !== 1'b0 || q0[0].ovf !== 1'b0) begin
        errors++;
        $display("FAIL t6_value: got step=%0d p=%0d sat=%b ovf=%b want 5 -11 0 0",
                 q0[0].at, q0[0].p, q0[0].sat, q0[0].ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_mult();
    test_frame();
    test_round_sat();
    test_ce_bubbles();
    test_back_to_back();
    test_restart();
    test_acc_ovf();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
